// File: rtl/shift_sequencer_if.sv
// Request/response bundle between ALU decode, the shift sequencer and the result mux.
// The master side issues operations and consumes results; the slave side is the sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [AMT_W-1:0] AMT;
    logic [1:0]       OP;
    logic             ABORT;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] C;
    logic             CARRY;
    logic             ZERO;
    logic             BUSY;

    modport master (
        output IN_VALID, A, AMT, OP, ABORT, OUT_READY,
        input  IN_READY, OUT_VALID, C, CARRY, ZERO, BUSY
    );

    modport slave (
        input  IN_VALID, A, AMT, OP, ABORT, OUT_READY,
        output IN_READY, OUT_VALID, C, CARRY, ZERO, BUSY
    );
endinterface

// File: rtl/shift_sequencer.sv
// N-position shift/rotate built from one single-step shifter; result valid AMT+1 cycles after acceptance.
// Holds C/CARRY/ZERO while OUT_READY is low; accepts requests only in IDLE, ABORT drops back to IDLE.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_res;
    logic             step_c;

    // One-position shifter: op[1] selects arithmetic vs rotate, op[0] selects right vs left.
    always_comb begin
        step_res = work_q;
        step_c   = 1'b0;
        case (op_q)
            2'b00: begin
                step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_c   = work_q[WIDTH-1];
            end
            2'b01: begin
                step_res = {work_q[0], work_q[WIDTH-1:1]};
                step_c   = work_q[0];
            end
            2'b10: begin
                step_res = {work_q[WIDTH-2:0], 1'b0};
                step_c   = work_q[WIDTH-1];
            end
            default: begin
                step_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_c   = work_q[0];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    work_d  = bus.A;
                    cnt_d   = bus.AMT;
                    op_d    = bus.OP;
                    carry_d = 1'b0;
                    zero_d  = (bus.A == '0);
                    state_d = (bus.AMT == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // An abort leaves work/carry/zero exactly as the last completed step left them.
                if (bus.ABORT) begin
                    state_d = IDLE;
                end else begin
                    work_d  = step_res;
                    carry_d = step_c;
                    zero_d  = (step_res == '0);
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.ABORT || bus.OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.OUT_VALID = (state_q == DONE);
    assign bus.C         = work_q;
    assign bus.CARRY     = carry_q;
    assign bus.ZERO      = zero_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random exercise of shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;
    logic CLK = 1'b0;
    logic RST;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fail_cnt  = 0;

    always #5 CLK = ~CLK;

    shift_sequencer_if #(.WIDTH(8), .AMT_W(3)) bus ();

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Returns {carry, result} for n whole-operand steps, computed directly.
    function automatic logic [8:0] ref_op(input logic [7:0] a, input int n, input logic [1:0] op);
        logic [15:0]       ext;
        logic [7:0]        r;
        logic signed [7:0] sa;
        logic              c;
        int                k;
        r  = a;
        c  = 1'b0;
        k  = n % 8;
        sa = a;
        if (n != 0) begin
            case (op)
                2'b00: begin ext = {a, a} << k; r = ext[15:8]; c = r[0]; end
                2'b01: begin ext = {a, a} >> k; r = ext[7:0];  c = r[7]; end
                2'b10: begin ext = {8'h00, a} << n; r = ext[7:0]; c = ext[8]; end
                default: begin r = sa >>> n; c = a[n-1]; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [8:0] m);
        check({tag, "_c"},     32'(bus.C),     32'(m[7:0]));
        check({tag, "_carry"}, 32'(bus.CARRY), 32'(m[8]));
        check({tag, "_zero"},  32'(bus.ZERO),  32'(m[7:0] == 8'h00));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ovalid"}, 32'(bus.OUT_VALID), 32'd0);
        check({tag, "_c"},      32'(bus.C),         32'd0);
        check({tag, "_carry"},  32'(bus.CARRY),     32'd0);
        check({tag, "_zero"},   32'(bus.ZERO),      32'd0);
        check({tag, "_busy"},   32'(bus.BUSY),      32'd0);
        check({tag, "_iready"}, 32'(bus.IN_READY),  32'd1);
    endtask

    // Issue one request, wait for the result, apply 'hold' cycles of backpressure, then release.
    task automatic do_op(input logic [7:0] a, input logic [2:0] amt, input logic [1:0] op,
                         input int hold, input logic abt);
        int         lat;
        logic [8:0] m;
        m = ref_op(a, int'(amt), op);
        check("accept_ready", 32'(bus.IN_READY), 32'd1);
        bus.IN_VALID  = 1'b1;
        bus.A         = a;
        bus.AMT       = amt;
        bus.OP        = op;
        bus.ABORT     = abt;
        bus.OUT_READY = 1'b0;
        step();
        bus.IN_VALID = 1'b0;
        bus.ABORT    = 1'b0;
        bus.A        = 8'($urandom);
        bus.AMT      = 3'($urandom);
        bus.OP       = 2'($urandom);
        lat = 1;
        while (bus.OUT_VALID !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(amt) + 32'd1);
        check_result("result", m);
        check("done_iready", 32'(bus.IN_READY), 32'd0);
        check("done_busy",   32'(bus.BUSY),     32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.IN_VALID = 1'b1;
            step();
            check("hold_ovalid", 32'(bus.OUT_VALID), 32'd1);
            check("hold_iready", 32'(bus.IN_READY),  32'd0);
            check_result("hold", m);
        end
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        step();
        bus.OUT_READY = 1'b0;
        check("release_iready", 32'(bus.IN_READY),  32'd1);
        check("release_ovalid", 32'(bus.OUT_VALID), 32'd0);
    endtask

    initial begin
        logic [8:0] m1;
        int         seen;
        RST           = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.A         = 8'h00;
        bus.AMT       = 3'd0;
        bus.OP        = 2'b00;
        bus.ABORT     = 1'b0;
        bus.OUT_READY = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        RST = 1'b0;
        step();

        do_op(8'h96, 3'd3, 2'b00, 0, 1'b0);
        do_op(8'h96, 3'd2, 2'b11, 0, 1'b0);
        do_op(8'h80, 3'd1, 2'b10, 0, 1'b0);
        do_op(8'h96, 3'd4, 2'b10, 0, 1'b0);
        do_op(8'h5A, 3'd0, 2'b01, 0, 1'b0);
        do_op(8'h01, 3'd1, 2'b01, 0, 1'b0);
        do_op(8'h96, 3'd3, 2'b00, 5, 1'b0);
        do_op(8'h6D, 3'd7, 2'b11, 1, 1'b0);

        // Abort during the second shift cycle of a 7-step rotate.
        m1 = ref_op(8'hA7, 1, 2'b01);
        bus.IN_VALID = 1'b1;
        bus.A        = 8'hA7;
        bus.AMT      = 3'd7;
        bus.OP       = 2'b01;
        step();
        bus.IN_VALID = 1'b0;
        step();
        check("abort_busy_before", 32'(bus.BUSY), 32'd1);
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        check("abort_iready", 32'(bus.IN_READY),  32'd1);
        check("abort_busy",   32'(bus.BUSY),      32'd0);
        check_result("abort_hold", m1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.OUT_VALID === 1'b1) seen++;
            step();
        end
        check("abort_no_pulse", 32'(seen), 32'd0);

        // Reset in the middle of a shift sequence.
        bus.IN_VALID = 1'b1;
        bus.A        = 8'hFF;
        bus.AMT      = 3'd5;
        bus.OP       = 2'b00;
        step();
        bus.IN_VALID = 1'b0;
        step();
        check("mid_busy", 32'(bus.BUSY), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_reset_outputs("mid_reset");

        // ABORT in IDLE must not block a simultaneous request.
        do_op(8'hC3, 3'd5, 2'b00, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            do_op(8'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that turns the single-position shift/rotate datapath into an N-position shift/rotate engine.
- Owns one instance of the one-step shifter and feeds its output back into a working register once per cycle until the requested amount is consumed.
- Sits between the ALU decode stage, which issues operations through a valid/ready handshake, and the ALU result mux.
- Also returns carry-out and zero flags.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_W, 3, width of the shift-amount field. Amounts 0..2^AMT_W-1 are legal.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  request present.
- IN_READY  output  1  sequencer can accept a request.
- A  input  WIDTH  operand.
- AMT  input  AMT_W  number of one-position steps.
- OP  input  2  operation select:
  - OP[1]: 1 = arithmetic shift, 0 = rotate.
  - OP[0]: 1 = right, 0 = left.
- ABORT  input  1  cancel the current operation.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer accepts the result.
- C  output  WIDTH  result.
- CARRY  output  1  last bit shifted or rotated out.
- ZERO  output  1  C == 0.
- BUSY  output  1  state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock.
  - RST is synchronous and active-high.
  - RST dominates all other inputs, including mid-operation: next state IDLE.
  - On reset, OUT_VALID=0, C=0, CARRY=0, ZERO=0, BUSY=0, IN_READY=1 (IN_READY is 1 in the cycle following reset).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1.
  - Acceptance is IN_VALID & IN_READY in cycle T.
  - On acceptance: work register <= A, count <= AMT, op register <= OP, CARRY <= 0.
  - If AMT==0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each cycle, work <= one-step shifter output for the registered op, CARRY <= bit leaving the operand, count <= count-1.
  - Go to DONE when count transitions 1->0.
- One-step semantics:
  - Rotate left: bit WIDTH-1 wraps to bit 0. CARRY = old bit WIDTH-1.
  - Rotate right: bit 0 wraps to bit WIDTH-1. CARRY = old bit 0.
  - Arithmetic left: zero fill into bit 0. CARRY = old bit WIDTH-1.
  - Arithmetic right: sign bit replicated. CARRY = old bit 0.
- Large amounts: no modulo reduction. Amounts >= WIDTH iterate fully. Arithmetic results saturate to all-sign or zero. Rotates wrap naturally.
- DONE:
  - OUT_VALID=1.
  - C = work register, ZERO = (work == 0).
  - C, CARRY and ZERO are held stable while OUT_VALID=1 && OUT_READY=0.
  - When OUT_READY=1, go to IDLE. OUT_VALID drops the next cycle.
  - No new request is accepted in DONE (IN_READY=0).
- Latency:
  - OUT_VALID first asserts at cycle T+1+AMT. AMT=0 gives T+1.
  - Throughput is one operation per AMT+2 cycles with OUT_READY held high.
- ABORT:
  - In SHIFT or DONE: next state IDLE, OUT_VALID=0 next cycle, result discarded. C, CARRY and ZERO keep their last values.
  - In IDLE: ignored, so a simultaneous IN_VALID is still accepted.
- Input stability: A, AMT and OP are sampled only at acceptance. Changes afterwards have no effect.
- Combinational outputs:
  - IN_READY = (state==IDLE).
  - BUSY = (state!=IDLE).
  - No combinational path from IN_VALID to IN_READY or from OUT_READY to OUT_VALID.

Test Plan:
- Rotate left by 3: A=0x96, OP=00, AMT=3, accepted at T -> OUT_VALID at T+4, C=0xB4, CARRY=0, ZERO=0.
- Arithmetic right by 2: A=0x96, OP=11, AMT=2 -> OUT_VALID at T+3, C=0xE5, CARRY=1. Sign is preserved through both steps.
- Arithmetic left to zero: A=0x80, OP=10, AMT=1 -> C=0x00, CARRY=1, ZERO=1. Then A=0x96, OP=10, AMT=4 -> C=0x60, CARRY=1.
- Zero amount and rotate right:
  - A=0x5A, OP=01, AMT=0 -> OUT_VALID at T+1, C=0x5A, CARRY=0.
  - A=0x01, OP=01, AMT=1 -> C=0x80, CARRY=1.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> C, CARRY and ZERO stable, IN_READY=0, IN_VALID ignored. Release OUT_READY -> IDLE next cycle and the next request is accepted.
- Abort and reset mid-operation:
  - ABORT in the second SHIFT cycle of AMT=7 -> IDLE next cycle, no OUT_VALID pulse.
  - RST asserted during SHIFT -> all outputs at reset values the next cycle.
  - ABORT together with IN_VALID in IDLE -> the request is accepted.
